// File: rtl/audio_pkg.sv
// Shared constants and FSM state type for the audio DAC serializer slice.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } dac_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous stereo-frame FIFO; head entry is visible on rdata while not empty.
module frame_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    rdata    = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified serial DAC output from a stereo frame FIFO, driven by
// codec BCLK/DACLRCK sampled into the CLOCK_50 domain.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underrun
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

  logic [1:0]              bclk_sync_q, bclk_sync_d, lrck_sync_q, lrck_sync_d;
  logic                    bclk_prev_q, bclk_prev_d, lrck_prev_q, lrck_prev_d;
  logic [1:0]              prime_q, prime_d;
  dac_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d, held_right_q, held_right_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    dacdat_q, dacdat_d, underrun_q, underrun_d;
  logic                    write_ready_q, write_ready_d;

  logic                    edges_valid, lrck_rise, lrck_fall, bclk_fall;
  logic                    push, pop;
  logic [2*DATA_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count, occ_next;

  frame_fifo #(
    .WIDTH(2 * DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLOCK_50),
    .reset(reset),
    .push (push),
    .wdata({writedata_left, writedata_right}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    bclk_sync_d   = {bclk_sync_q[0], AUD_BCLK};
    lrck_sync_d   = {lrck_sync_q[0], AUD_DACLRCK};
    bclk_prev_d   = bclk_sync_q[1];
    lrck_prev_d   = lrck_sync_q[1];
    prime_d       = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    // Edges are masked until sync and prev hold real samples, so a line
    // already high at reset release is not mistaken for a rising edge.
    edges_valid   = (prime_q == 2'd3);
    lrck_rise     = edges_valid &&  lrck_sync_q[1] && !lrck_prev_q;
    lrck_fall     = edges_valid && !lrck_sync_q[1] &&  lrck_prev_q;
    bclk_fall     = edges_valid && !bclk_sync_q[1] &&  bclk_prev_q;

    push          = write && write_ready_q && !fifo_full;
    pop           = lrck_rise;
    occ_next      = fifo_count + CW'(push) - CW'(pop && !fifo_empty);
    write_ready_d = (occ_next < CW'(DEPTH));

    state_d       = state_q;
    shift_d       = shift_q;
    held_right_d  = held_right_q;
    bit_cnt_d     = bit_cnt_q;
    dacdat_d      = dacdat_q;
    underrun_d    = 1'b0;

    if (lrck_rise) begin
      state_d = LEFT;
      if (fifo_empty) begin
        shift_d      = '0;
        held_right_d = '0;
        underrun_d   = 1'b1;
      end else begin
        shift_d      = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        held_right_d = fifo_rdata[DATA_WIDTH-1:0];
      end
      dacdat_d  = shift_d[DATA_WIDTH-1];
      bit_cnt_d = BW'(1);
    end else if (lrck_fall && state_q != WAIT_SYNC) begin
      state_d   = RIGHT;
      shift_d   = held_right_q;
      dacdat_d  = held_right_q[DATA_WIDTH-1];
      bit_cnt_d = BW'(1);
    end else if (bclk_fall && state_q != WAIT_SYNC) begin
      shift_d = shift_q << 1;
      if (bit_cnt_q < BW'(DATA_WIDTH)) begin
        dacdat_d  = shift_q[DATA_WIDTH-2];
        bit_cnt_d = bit_cnt_q + BW'(1);
      end else begin
        dacdat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_q   <= '0;
      lrck_sync_q   <= '0;
      bclk_prev_q   <= 1'b0;
      lrck_prev_q   <= 1'b0;
      prime_q       <= '0;
      state_q       <= WAIT_SYNC;
      shift_q       <= '0;
      held_right_q  <= '0;
      bit_cnt_q     <= '0;
      dacdat_q      <= 1'b0;
      underrun_q    <= 1'b0;
      write_ready_q <= 1'b0;
    end else begin
      bclk_sync_q   <= bclk_sync_d;
      lrck_sync_q   <= lrck_sync_d;
      bclk_prev_q   <= bclk_prev_d;
      lrck_prev_q   <= lrck_prev_d;
      prime_q       <= prime_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      held_right_q  <= held_right_d;
      bit_cnt_q     <= bit_cnt_d;
      dacdat_q      <= dacdat_d;
      underrun_q    <= underrun_d;
      write_ready_q <= write_ready_d;
    end
  end

  assign write_ready = write_ready_q;
  assign AUD_DACDAT  = dacdat_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Codec-side bench: drives BCLK/DACLRCK slots and random writes, and checks the
// serial stream, write_ready and underrun against a frame-queue model.
module tb_audio_dac_serializer;

  localparam int W         = 24;
  localparam int DEPTH     = 4;
  localparam int H         = 4;   // CLOCK_50 cycles per BCLK half period
  localparam int SLOT_BITS = 32;
  localparam int N_FRAMES  = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write = 1'b0;
  logic [W-1:0] wl = '0, wr = '0;
  logic         write_ready;
  logic         AUD_BCLK = 1'b1;
  logic         AUD_DACLRCK = 1'b0;
  logic         AUD_DACDAT;
  logic         underrun;

  audio_dac_serializer #(
    .DATA_WIDTH(W),
    .DEPTH(DEPTH)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .write          (write),
    .writedata_left (wl),
    .writedata_right(wr),
    .write_ready    (write_ready),
    .AUD_BCLK       (AUD_BCLK),
    .AUD_DACLRCK    (AUD_DACLRCK),
    .AUD_DACDAT     (AUD_DACDAT),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ur_cnt  = 0;

  // Reference model: queue of {left,right} frames plus codec-facing state.
  logic [2*W-1:0] model_q[$];
  logic [2*W-1:0] directed_q[$];
  logic [W-1:0]   held_right = '0;
  bit             waiting = 1'b1;

  always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic try_write();
    logic [2*W-1:0] f;
    if (directed_q.size() > 0) f = directed_q.pop_front();
    else f = {$urandom(), $urandom()};
    check_eq("write_ready", {31'd0, write_ready}, {31'd0, model_q.size() < DEPTH});
    wl    = f[2*W-1:W];
    wr    = f[W-1:0];
    write = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(f);
  endtask

  task automatic do_reset();
    write = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
    check_eq("rst_write_ready", {31'd0, write_ready}, 32'd0);
    check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, write_ready}, 32'd1);
    model_q.delete();
    waiting    = 1'b1;
    held_right = '0;
  endtask

  // One channel slot of SLOT_BITS bit periods; DACDAT checked at the end of
  // each BCLK-high phase, where the codec would sample it.
  task automatic run_slot(input bit lr_change, input logic lr_val, input logic [W-1:0] word,
                          input int n_wr, input int reset_bit);
    logic [W-1:0] w;
    int off;
    w   = word;
    off = $urandom_range(0, 2);
    for (int b = 0; b < SLOT_BITS; b++) begin
      AUD_BCLK = 1'b0;
      for (int c = 0; c < H; c++) begin
        if (b == 0 && lr_change && c == off) AUD_DACLRCK = lr_val;
        @(negedge clk);
      end
      AUD_BCLK = 1'b1;
      for (int c = 0; c < H; c++) begin
        if (c == 0 && b >= 8 && b < 8 + n_wr) try_write();
        else write = 1'b0;
        @(negedge clk);
      end
      write = 1'b0;
      check_eq($sformatf("dacdat_bit%0d", b), {31'd0, AUD_DACDAT},
               {31'd0, (b < W) ? w[W-1-b] : 1'b0});
      if (b == reset_bit) begin
        do_reset();
        w = '0;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] f;
    logic [W-1:0]   lw;
    int             exp_ur, ur0, rst_bit;
    bit             after_reset;

    repeat (4) @(negedge clk);
    check_eq("init_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
    check_eq("init_write_ready", {31'd0, write_ready}, 32'd0);
    check_eq("init_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, write_ready}, 32'd1);

    // BCLK running with no DACLRCK edge: silent; 5 writes fill DEPTH=4.
    directed_q.push_back({24'h800001, 24'h7FFFFE});
    run_slot(1'b0, 1'b0, '0, 5, -1);

    after_reset = 1'b0;
    for (int fr = 0; fr < N_FRAMES; fr++) begin
      if (model_q.size() == 0) begin
        lw         = '0;
        held_right = '0;
        exp_ur     = 1;
      end else begin
        f          = model_q.pop_front();
        lw         = f[2*W-1:W];
        held_right = f[W-1:0];
        exp_ur     = 0;
      end
      waiting = 1'b0;
      rst_bit = (fr == 6) ? 10 : -1;
      ur0     = ur_cnt;
      run_slot(1'b1, 1'b1, lw, 0, rst_bit);
      check_eq("underrun_pulses", ur_cnt - ur0, exp_ur);
      after_reset = (fr == 6);
      run_slot(1'b1, 1'b0, waiting ? '0 : held_right,
               after_reset ? 0 : $urandom_range(0, 4), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
